// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the HI/LO sequencer and its watchdog.
package muldiv_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_START = 3'd1,
    D_WAIT  = 3'd2,
    M_START = 3'd3,
    M_WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/hilo_unit_if.sv
// Bundle between control unit / mult-div engines and the HI/LO sequencer.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             DivReq;
  logic             MultReq;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] RegIn;
  logic             ClearFlags;
  logic             DtoC;
  logic             DivZero;
  logic [WIDTH-1:0] DivHigh;
  logic [WIDTH-1:0] DivLow;
  logic             MtoC;
  logic [WIDTH-1:0] MultHigh;
  logic [WIDTH-1:0] MultLow;
  logic             CtoD;
  logic             CtoM;
  logic             Busy;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             DivZeroFlag;
  logic             TimeoutFlag;

  modport master (
    output DivReq, MultReq, HiWrite, LoWrite, RegIn,
    output ClearFlags, DtoC, DivZero, DivHigh, DivLow,
    output MtoC, MultHigh, MultLow,
    input  CtoD, CtoM, Busy, HiOut, LoOut,
    input  DivZeroFlag, TimeoutFlag
  );

  modport slave (
    input  DivReq, MultReq, HiWrite, LoWrite, RegIn,
    input  ClearFlags, DtoC, DivZero, DivHigh, DivLow,
    input  MtoC, MultHigh, MultLow,
    output CtoD, CtoM, Busy, HiOut, LoOut,
    output DivZeroFlag, TimeoutFlag
  );
endinterface

// File: rtl/muldiv_watchdog.sv
// WAIT-state cycle counter; expire is high on the last allowed WAIT cycle.
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active) begin
      count <= count + 1'b1;
    end
  end

  assign expire = active && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair and mult/div sequencer.
// Optional WAIT watchdog enabled by defining MULDIV_WATCHDOG_EN.
module hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic        Clock,
  input logic        Reset,
  hilo_unit_if.slave bus
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("hilo_unit: TIMEOUT must be at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz_flag;
  logic             to_flag;
  logic             d_done;
  logic             m_done;
  logic             expire;

  assign d_done = (state == D_WAIT) && bus.DtoC;
  assign m_done = (state == M_WAIT) && bus.MtoC;

`ifdef MULDIV_WATCHDOG_EN
  logic wd_expire;

  muldiv_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .Clock (Clock),
    .Reset (Reset),
    .clear ((state == D_START) || (state == M_START)),
    .active((state == D_WAIT) || (state == M_WAIT)),
    .expire(wd_expire)
  );

  // a done arriving on the last cycle still commits normally
  assign expire = wd_expire && !d_done && !m_done;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      to_flag <= 1'b0;
    end else if (expire) begin
      to_flag <= 1'b1;
    end else if (bus.ClearFlags) begin
      to_flag <= 1'b0;
    end
  end
`else
  assign expire  = 1'b0;
  assign to_flag = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.DivReq) begin
          state_nxt = D_START;
        end else if (bus.MultReq) begin
          state_nxt = M_START;
        end
      end
      D_START: state_nxt = D_WAIT;
      M_START: state_nxt = M_WAIT;
      D_WAIT: begin
        if (d_done || expire) begin
          state_nxt = IDLE;
        end
      end
      M_WAIT: begin
        if (m_done || expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // MTHI/MTLO only in IDLE, so they never collide with a commit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (bus.HiWrite) begin
        hi <= bus.RegIn;
      end
      if (bus.LoWrite) begin
        lo <= bus.RegIn;
      end
    end else if (d_done && !bus.DivZero) begin
      hi <= bus.DivHigh;
      lo <= bus.DivLow;
    end else if (m_done) begin
      hi <= bus.MultHigh;
      lo <= bus.MultLow;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dz_flag <= 1'b0;
    end else if (d_done && bus.DivZero) begin
      dz_flag <= 1'b1;
    end else if (bus.ClearFlags) begin
      dz_flag <= 1'b0;
    end
  end

  assign bus.CtoD        = (state == D_START);
  assign bus.CtoM        = (state == M_START);
  assign bus.Busy        = (state != IDLE);
  assign bus.HiOut       = hi;
  assign bus.LoOut       = lo;
  assign bus.DivZeroFlag = dz_flag;
  assign bus.TimeoutFlag = to_flag;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with randomized engine latencies and data.
// Build with MULDIV_WATCHDOG_EN to also exercise the watchdog (TIMEOUT=8).
module tb_hilo_unit;

`ifdef MULDIV_WATCHDOG_EN
  localparam int TO   = 8;
  localparam int LMAX = TO - 3;
`else
  localparam int TO   = 64;
  localparam int LMAX = 40;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_dz;
  bit          m_to;

  hilo_unit_if #(.WIDTH(32)) bus ();

  hilo_unit #(
    .WIDTH  (32),
    .TIMEOUT(TO)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.DivReq     = 0;
    bus.MultReq    = 0;
    bus.HiWrite    = 0;
    bus.LoWrite    = 0;
    bus.RegIn      = '0;
    bus.ClearFlags = 0;
    bus.DtoC       = 0;
    bus.DivZero    = 0;
    bus.DivHigh    = '0;
    bus.DivLow     = '0;
    bus.MtoC       = 0;
    bus.MultHigh   = '0;
    bus.MultLow    = '0;
  endtask

  task automatic check_state(input string name, input bit busy);
    checks++;
    if (bus.Busy !== busy || bus.HiOut !== m_hi || bus.LoOut !== m_lo ||
        bus.DivZeroFlag !== m_dz || bus.TimeoutFlag !== m_to ||
        bus.CtoD !== 1'b0 || bus.CtoM !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b hi=%h lo=%h dz=%b to=%b ctod=%b ctom=%b want busy=%b hi=%h lo=%h dz=%b to=%b ctod=0 ctom=0",
               name, bus.Busy, bus.HiOut, bus.LoOut, bus.DivZeroFlag,
               bus.TimeoutFlag, bus.CtoD, bus.CtoM, busy, m_hi, m_lo, m_dz, m_to);
    end
  endtask

  task automatic idle_write(input bit wh, input bit wl, input logic [31:0] v);
    @(negedge clk);
    bus.HiWrite = wh;
    bus.LoWrite = wl;
    bus.RegIn   = v;
    @(negedge clk);
    clear_inputs();
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check_state("idle_write", 1'b0);
  endtask

  // One full MULT/DIV transaction driven like the control unit plus engine.
  task automatic run_op(input bit is_div, input bit both_req, input int lat,
                        input logic [31:0] h, input logic [31:0] l, input bit z,
                        input bit clr, input bit wr_req, input bit wr_busy,
                        input bit stray);
    int          bad;
    logic [31:0] wv;
    @(negedge clk);
    if (is_div) bus.DivReq = 1;
    else bus.MultReq = 1;
    if (both_req) bus.MultReq = 1;
    if (wr_req) begin
      wv = $urandom;
      bus.HiWrite = 1;
      bus.RegIn   = wv;
      m_hi        = wv;
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bus.CtoD !== is_div || bus.CtoM !== !is_div || bus.Busy !== 1'b1 ||
        bus.HiOut !== m_hi) begin
      errors++;
      $display("FAIL start: ctod=%b ctom=%b busy=%b hi=%h want ctod=%b ctom=%b busy=1 hi=%h",
               bus.CtoD, bus.CtoM, bus.Busy, bus.HiOut, is_div, !is_div, m_hi);
    end
    bad = 0;
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) clear_inputs();
      if (i == 0) @(negedge clk);
      if (bus.CtoD !== 1'b0 || bus.CtoM !== 1'b0 || bus.Busy !== 1'b1 ||
          bus.HiOut !== m_hi || bus.LoOut !== m_lo) bad++;
      if (i == 0 && wr_busy) begin
        bus.HiWrite = 1;
        bus.LoWrite = 1;
        bus.RegIn   = $urandom;
      end
      if (i == 0 && stray) begin
        if (is_div) begin
          bus.MtoC     = 1;
          bus.MultHigh = $urandom;
          bus.MultLow  = $urandom;
        end else begin
          bus.DtoC    = 1;
          bus.DivZero = $urandom_range(0, 1);
          bus.DivHigh = $urandom;
          bus.DivLow  = $urandom;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait: %0d bad wait cycles, required 0", bad);
    end
    clear_inputs();
    if (is_div) begin
      bus.DtoC    = 1;
      bus.DivZero = z;
      bus.DivHigh = h;
      bus.DivLow  = l;
    end else begin
      bus.MtoC     = 1;
      bus.MultHigh = h;
      bus.MultLow  = l;
    end
    bus.ClearFlags = clr;
    @(negedge clk);
    clear_inputs();
    if (is_div && z) begin
      m_dz = 1;
      if (clr) m_to = 0;
    end else begin
      m_hi = h;
      m_lo = l;
      if (clr) begin
        m_dz = 0;
        m_to = 0;
      end
    end
    check_state(is_div ? "div_done" : "mult_done", 1'b0);
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    m_hi = 0;
    m_lo = 0;
    m_dz = 0;
    m_to = 0;
    repeat (2) @(negedge clk);
    check_state("reset_initial", 1'b0);
    rst = 0;
    idle_write(1, 1, 32'h5555_AAAA);
    @(negedge clk);
    bus.DivReq = 1;
    @(negedge clk);
    bus.DivReq = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    m_hi = 0;
    m_lo = 0;
    check_state("reset_mid_wait", 1'b0);
    @(negedge clk);
    rst = 0;
    bus.DtoC    = 1;
    bus.DivHigh = 32'hDEAD_BEEF;
    bus.DivLow  = 32'hCAFE_F00D;
    @(negedge clk);
    clear_inputs();
    check_state("done_after_reset", 1'b0);
  endtask

  task automatic test_div();
    int lat;
`ifdef MULDIV_WATCHDOG_EN
    lat = LMAX;
`else
    lat = 31;
`endif
    run_op(1, 0, lat, 32'd1, 32'd33, 0, 0, 0, 0, 0);
    run_op(0, 0, 3, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 0, 0, 0, 0, 0);
  endtask

  task automatic test_divzero();
    idle_write(1, 1, 32'hA5A5_A5A5);
    run_op(1, 0, 4, 32'h1111_2222, 32'h3333_4444, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_state("dz_sticky", 1'b0);
    @(negedge clk);
    bus.ClearFlags = 1;
    @(negedge clk);
    clear_inputs();
    m_dz = 0;
    check_state("dz_cleared", 1'b0);
    run_op(1, 0, 2, 32'h0, 32'h0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_priority();
    run_op(1, 1, 5, 32'h0000_0007, 32'h0000_0009, 0, 0, 0, 0, 1);
    run_op(0, 0, 4, 32'h1234_0000, 32'h0000_5678, 0, 0, 0, 0, 1);
  endtask

  task automatic test_write();
    idle_write(1, 0, 32'h1234_5678);
    idle_write(0, 1, 32'h8765_4321);
    run_op(0, 0, 3, 32'h0BAD_0001, 32'h0BAD_0002, 0, 0, 0, 1, 0);
    run_op(1, 0, 3, 32'h0000_0002, 32'h0000_0003, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.DtoC    = 1;
    bus.MtoC    = 1;
    bus.DivHigh = 32'hFACE_FACE;
    bus.MultLow = 32'hFEED_FEED;
    @(negedge clk);
    clear_inputs();
    check_state("done_in_idle", 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(1, LMAX), $urandom, $urandom,
             $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_timeout();
`ifdef MULDIV_WATCHDOG_EN
    int n;
    @(negedge clk);
    bus.MultReq = 1;
    @(negedge clk);
    bus.MultReq = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Busy) break;
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_len: wait cycles=%0d want %0d", n, TO);
    end
    m_to = 1;
    check_state("timeout_flag", 1'b0);
    @(negedge clk);
    bus.ClearFlags = 1;
    @(negedge clk);
    clear_inputs();
    m_to = 0;
    check_state("timeout_cleared", 1'b0);
`else
    repeat (2) @(negedge clk);
    check_state("timeout_tied_low", 1'b0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div();
    test_divzero();
    test_priority();
    test_write();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
